// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for a 5-stage pipeline covering load-use,
// taken-branch and multi-cycle data-memory hazards, with a memory-timeout watchdog.
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ID_EX_MemRead_i,
   input  logic [4:0]       ID_EX_Rd_i,
   input  logic [4:0]       IF_ID_Rs1_i,
   input  logic [4:0]       IF_ID_Rs2_i,
   input  logic             Branch_taken_i,
   input  logic             EX_MEM_MemAccess_i,
   input  logic             DMemAck_i,
   output logic             PCWrite_o,
   output logic             IF_ID_Write_o,
   output logic             IF_ID_Flush_o,
   output logic             ID_EX_Write_o,
   output logic             ID_EX_Bubble_o,
   output logic             EX_MEM_Write_o,
   output logic             MEM_WB_Bubble_o,
   output logic             DMemReq_o,
   output logic             Err_o,
   output logic [CNT_W-1:0] StallCnt_o,
   output logic [CNT_W-1:0] FlushCnt_o
);
   typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
   localparam logic [7:0] TO = 8'(TIMEOUT);

   state_t state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic [CNT_W-1:0] stall_q, flush_q;
   logic active, memstall, loaduse;

   assign active   = !rst_i && state_q != ERROR;
   assign memstall = active && EX_MEM_MemAccess_i && !DMemAck_i;
   assign loaduse  = ID_EX_MemRead_i && ID_EX_Rd_i != 5'd0 &&
                     (ID_EX_Rd_i == IF_ID_Rs1_i || ID_EX_Rd_i == IF_ID_Rs2_i);

   // Priority: memory wait, then load-use, then taken branch
   assign PCWrite_o       = active && !memstall && !loaduse;
   assign IF_ID_Write_o   = active && !memstall && !loaduse;
   assign IF_ID_Flush_o   = active && !memstall && !loaduse && Branch_taken_i;
   assign ID_EX_Write_o   = active && !memstall;
   assign ID_EX_Bubble_o  = active && !memstall && loaduse;
   assign EX_MEM_Write_o  = active && !memstall;
   assign MEM_WB_Bubble_o = memstall;
   assign DMemReq_o       = active && EX_MEM_MemAccess_i;
   assign Err_o           = !rst_i && state_q == ERROR;
   assign StallCnt_o      = stall_q;
   assign FlushCnt_o      = flush_q;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      if (state_q == RUN && memstall) begin
         state_d = MEM_WAIT;
         wait_d  = 8'd1;
      end else if (state_q == MEM_WAIT) begin
         if (!memstall) begin
            state_d = RUN;
            wait_d  = 8'd0;
         end else if (wait_q == TO) begin
            state_d = ERROR;
         end else begin
            wait_d = wait_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RUN;
         wait_q  <= 8'd0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         stall_q <= (active && !PCWrite_o && ~&stall_q) ? stall_q + 1'b1 : stall_q;
         flush_q <= (IF_ID_Flush_o && ~&flush_q) ? flush_q + 1'b1 : flush_q;
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks of pipeline_hazard_ctrl against a
// priority-rule reference model that tracks consecutive un-acked request cycles.
module tb_pipeline_hazard_ctrl;
   localparam int TO = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic rd_load = 1'b0, br = 1'b0, acc = 1'b0, ack = 1'b0;
   logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
   logic pcw, ifw, ifl, idw, idb, exw, mwb, req, err;
   logic [31:0] stall_cnt, flush_cnt;
   logic [8:0] outs;
   int tests = 0, fails = 0;
   logic m_err;
   int m_waits;
   logic [31:0] m_stall, m_flush;

   pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .ID_EX_MemRead_i(rd_load), .ID_EX_Rd_i(rd), .IF_ID_Rs1_i(rs1), .IF_ID_Rs2_i(rs2),
      .Branch_taken_i(br), .EX_MEM_MemAccess_i(acc), .DMemAck_i(ack),
      .PCWrite_o(pcw), .IF_ID_Write_o(ifw), .IF_ID_Flush_o(ifl), .ID_EX_Write_o(idw),
      .ID_EX_Bubble_o(idb), .EX_MEM_Write_o(exw), .MEM_WB_Bubble_o(mwb), .DMemReq_o(req),
      .Err_o(err), .StallCnt_o(stall_cnt), .FlushCnt_o(flush_cnt)
   );

   assign outs = {pcw, ifw, ifl, idw, idb, exw, mwb, req, err};
   always #5 clk = ~clk;

   // Expected {PCWrite, IF_ID_Write, Flush, ID_EX_Write, Bubble, EX_MEM_Write, MEM_WB_Bubble, Req, Err}
   function automatic logic [8:0] model_out();
      logic lu;
      if (rst) return 9'b0;
      if (m_err) return 9'b000000001;
      if (acc && !ack) return 9'b000000110;
      lu = rd_load && rd != 5'd0 && (rd == rs1 || rd == rs2);
      if (lu) return {7'b0001110, acc, 1'b0};
      return {2'b11, br, 4'b1010, acc, 1'b0};
   endfunction

   task automatic model_update(input logic [8:0] e);
      if (!m_err && !e[8] && m_stall != '1) m_stall++;
      if (e[6] && m_flush != '1) m_flush++;
      if (!m_err) begin
         if (acc && !ack) begin
            m_waits++;
            if (m_waits > TO) m_err = 1'b1;
         end else m_waits = 0;
      end
   endtask

   task automatic clear_model();
      m_err = 1'b0; m_waits = 0; m_stall = '0; m_flush = '0;
   endtask

   task automatic tick();
      logic [8:0] e;
      e = model_out();
      @(posedge clk);
      model_update(e);
      #1;
   endtask

   task automatic drive(input logic l, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic b, input logic a, input logic k);
      rd_load = l; rd = d; rs1 = s1; rs2 = s2; br = b; acc = a; ack = k;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      clear_model();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1, 5, 5, 5, 1, 1, 0);
      #2;
      tests++;
      if (outs !== 9'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin
         fails++;
         $display("FAIL reset: outs=%b stall=%0d flush=%0d, required all zero", outs, stall_cnt, flush_cnt);
      end
      do_reset();
      #2;
      tests++;
      if (outs !== 9'b110101000) begin
         fails++; $display("FAIL reset_idle: outs=%b required %b", outs, 9'b110101000);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 5, 3, 5, 0, 0, 0);
      #2;
      tests++;
      if (outs !== 9'b000111000) begin
         fails++; $display("FAIL load_use: outs=%b required %b", outs, 9'b000111000);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      tests++;
      if (outs !== 9'b110101000 || stall_cnt !== 1) begin
         fails++; $display("FAIL load_use_after: outs=%b stall=%0d required %b stall=1", outs, stall_cnt, 9'b110101000);
      end
      tick();
   endtask

   task automatic test_rd_zero();
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 0);
      #2;
      tests++;
      if (outs !== 9'b110101000) begin
         fails++; $display("FAIL rd_zero: outs=%b required %b", outs, 9'b110101000);
      end
      tick();
      tests++;
      if (stall_cnt !== 0) begin
         fails++; $display("FAIL rd_zero_cnt: stall=%0d required 0", stall_cnt);
      end
   endtask

   task automatic test_branch();
      do_reset();
      drive(0, 0, 0, 0, 1, 0, 0);
      #2;
      tests++;
      if (outs !== 9'b111101000) begin
         fails++; $display("FAIL branch: outs=%b required %b", outs, 9'b111101000);
      end
      tick();
      tests++;
      if (flush_cnt !== 1) begin
         fails++; $display("FAIL branch_cnt: flush=%0d required 1", flush_cnt);
      end
      drive(1, 7, 7, 2, 1, 0, 0);
      #2;
      tests++;
      if (outs !== 9'b000111000) begin
         fails++; $display("FAIL branch_loaduse: outs=%b required %b", outs, 9'b000111000);
      end
      tick();
      tests++;
      if (flush_cnt !== 1 || stall_cnt !== 1) begin
         fails++; $display("FAIL branch_loaduse_cnt: flush=%0d stall=%0d required 1 1", flush_cnt, stall_cnt);
      end
   endtask

   task automatic test_mem_wait();
      int reqs = 0;
      do_reset();
      drive(0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         #2;
         tests++;
         if (outs !== 9'b000000110) begin
            fails++; $display("FAIL mem_wait_%0d: outs=%b required %b", i, outs, 9'b000000110);
         end
         reqs += int'(req);
         tick();
      end
      ack = 1'b1;
      #2;
      tests++;
      if (outs !== 9'b110101010) begin
         fails++; $display("FAIL mem_ack: outs=%b required %b", outs, 9'b110101010);
      end
      reqs += int'(req);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      tests++;
      if (outs !== 9'b110101000 || stall_cnt !== 3 || reqs != 4) begin
         fails++; $display("FAIL mem_done: outs=%b stall=%0d reqs=%0d required %b 3 4", outs, stall_cnt, reqs, 9'b110101000);
      end
      acc = 1'b1;
      for (int i = 0; i < TO; i++) tick();
      ack = 1'b1;
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      tests++;
      if (outs !== 9'b110101000 || stall_cnt !== 7) begin
         fails++; $display("FAIL mem_rewait: outs=%b stall=%0d required %b 7", outs, stall_cnt, 9'b110101000);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      drive(0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i <= TO; i++) begin
         #2;
         tests++;
         if (outs !== 9'b000000110) begin
            fails++; $display("FAIL timeout_wait_%0d: outs=%b required %b", i, outs, 9'b000000110);
         end
         tick();
      end
      ack = 1'b1;
      br = 1'b1;
      #2;
      tests++;
      if (outs !== 9'b000000001 || stall_cnt !== TO + 1) begin
         fails++; $display("FAIL timeout_err: outs=%b stall=%0d required %b %0d", outs, stall_cnt, 9'b000000001, TO + 1);
      end
      tick();
      tick();
      tests++;
      if (outs !== 9'b000000001 || stall_cnt !== TO + 1 || flush_cnt !== 0) begin
         fails++; $display("FAIL timeout_hold: outs=%b stall=%0d flush=%0d", outs, stall_cnt, flush_cnt);
      end
      #1 rst = 1'b1;
      #1;
      tests++;
      if (err !== 1'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin
         fails++; $display("FAIL timeout_rst: err=%b stall=%0d flush=%0d required 0", err, stall_cnt, flush_cnt);
      end
      do_reset();
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();
      tick();
      #2;
      tests++;
      if (outs !== 9'b000000110 || stall_cnt !== 2) begin
         fails++; $display("FAIL async_pre: outs=%b stall=%0d required %b 2", outs, stall_cnt, 9'b000000110);
      end
      rst = 1'b1;
      #1;
      tests++;
      if (outs !== 9'b0 || stall_cnt !== 0) begin
         fails++; $display("FAIL async_rst: outs=%b stall=%0d required all zero", outs, stall_cnt);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      clear_model();
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      tests++;
      if (outs !== 9'b110101000) begin
         fails++; $display("FAIL async_after: outs=%b required %b", outs, 9'b110101000);
      end
   endtask

   task automatic test_random();
      logic [8:0] e;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
               $urandom_range(0, 1));
         #2;
         e = model_out();
         tests++;
         if (outs !== e) begin
            fails++; $display("FAIL random_out_%0d: outs=%b required %b", i, outs, e);
         end
         tick();
         tests++;
         if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
            fails++; $display("FAIL random_cnt_%0d: stall=%0d flush=%0d required %0d %0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
         end
      end
   endtask

   initial begin
      clear_model();
      test_reset();
      test_load_use();
      test_rd_zero();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three hazard sources: load-use hazards, taken-branch flushes, and multi-cycle data-memory accesses through a req/ack handshake.
- Includes a memory-timeout watchdog and saturating performance counters.

Parameters:
- TIMEOUT, 16, consecutive un-acked memory-wait cycles before the block enters ERROR (legal range 1..255).
- CNT_W, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- ID_EX_MemRead_i  in  1  instruction in EX is a load
- ID_EX_Rd_i  in  5  destination register of the instruction in EX
- IF_ID_Rs1_i  in  5  rs1 of the instruction in ID
- IF_ID_Rs2_i  in  5  rs2 of the instruction in ID
- Branch_taken_i  in  1  branch in ID resolved taken
- EX_MEM_MemAccess_i  in  1  instruction in MEM performs a load or store
- DMemAck_i  in  1  data memory completes the access this cycle
- PCWrite_o  out  1  PC update enable
- IF_ID_Write_o  out  1  IF/ID load enable
- IF_ID_Flush_o  out  1  IF/ID cleared to NOP on the next edge
- ID_EX_Write_o  out  1  ID/EX load enable
- ID_EX_Bubble_o  out  1  ID/EX control fields loaded as zero
- EX_MEM_Write_o  out  1  EX/MEM load enable
- MEM_WB_Bubble_o  out  1  MEM/WB control fields loaded as zero
- DMemReq_o  out  1  data-memory request
- Err_o  out  1  sticky memory-timeout error
- StallCnt_o  out  CNT_W  cycles with PCWrite_o=0, excluding reset and ERROR
- FlushCnt_o  out  CNT_W  cycles with IF_ID_Flush_o=1

Behaviour:
- Reset is asynchronous and active-high. Clock is clk_i; reset is rst_i.
- While rst_i=1:
  - State=RUN, wait counter=0, Err_o=0, StallCnt_o=0, FlushCnt_o=0.
  - All enables, bubbles, flushes and DMemReq_o are forced to 0.
- Reset mid-wait abandons the access; DMemReq_o drops immediately.
- States: RUN, MEM_WAIT, ERROR. Control outputs are combinational from state plus inputs. Counters and state are registered.
- Default in RUN with no hazard: all write enables = 1; bubbles, flushes and DMemReq_o = 0.
- Memory condition (memstall) has top priority:
  - Applies in RUN or MEM_WAIT when EX_MEM_MemAccess_i=1.
  - DMemReq_o=1.
  - If DMemAck_i=0: PCWrite, IF_ID_Write, ID_EX_Write and EX_MEM_Write = 0; MEM_WB_Bubble=1; IF_ID_Flush=0; ID_EX_Bubble=0.
  - If DMemAck_i=1: the access completes this cycle and the pipeline advances normally. The lower-priority rules then apply.
  - DMemReq_o stays high every cycle until ack. There is no re-request after ack, because the MEM instruction advances on the ack edge.
- Load-use rule (second priority):
  - Condition: ID_EX_MemRead_i=1, ID_EX_Rd_i!=0, and ID_EX_Rd_i equals IF_ID_Rs1_i or IF_ID_Rs2_i.
  - Response: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - Branch_taken_i is ignored in that cycle; the branch is re-evaluated next cycle.
- Branch rule (third priority): Branch_taken_i=1 with no higher-priority condition gives IF_ID_Flush=1 and PCWrite=1.
- Transitions:
  - RUN to MEM_WAIT: memstall with no ack; wait counter becomes 1.
  - MEM_WAIT to RUN: ack received; wait counter cleared.
  - MEM_WAIT, no ack, counter < TIMEOUT: counter increments.
  - MEM_WAIT, no ack, counter == TIMEOUT: next state ERROR.
  - Result: ERROR is entered on the edge ending the (TIMEOUT+1)-th consecutive un-acked request cycle.
  - EX_MEM_MemAccess_i falling in MEM_WAIT without ack: return to RUN and clear the counter. This is a protocol violation; no error is flagged.
- ERROR:
  - Err_o=1, all write enables 0, DMemReq_o=0, all bubbles and flushes 0.
  - Held until reset.
- Counters:
  - StallCnt_o increments on each edge where PCWrite_o=0 in RUN or MEM_WAIT.
  - FlushCnt_o increments on each edge where IF_ID_Flush_o=1.
  - Both saturate at all-ones; no wrap.

Test Plan:
- Load-use: ID_EX_MemRead=1, Rd=5, Rs2=5 for one cycle → PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly 1 cycle; StallCnt=1.
- Rd=0 guard: MemRead=1, Rd=0, Rs1=0 → no stall; all enables 1.
- Branch flush, plus load-use-with-branch: Branch_taken=1 → IF_ID_Flush=1, FlushCnt=1. The same cycle combined with a load-use hazard → no flush, stall only.
- Memory wait: MemAccess=1, ack after 3 cycles → DMemReq high 4 cycles, PCWrite=0 and MEM_WB_Bubble=1 for 3 cycles; advance on the ack cycle; StallCnt=3; state back in RUN.
- Timeout: TIMEOUT=4, ack never → ERROR after 5 request cycles; Err_o=1, DMemReq=0, all enables 0. Pulse rst_i → Err_o=0, counters 0.
- Async reset mid-MEM_WAIT: assert rst_i between clock edges → outputs drop to 0 immediately, before the next edge.
